// File: rtl/enigma_buf_sched_if.sv
// Bus bundle for the enigma buffer scheduler: two ingress request ports (A, B),
// the registered output slot (C) with its release/congestion sideband, and status.
interface enigma_buf_sched_if #(
   parameter int PAYLOAD_W = 128,
   parameter int ID_W      = 5
);
   logic [PAYLOAD_W-1:0] payload_a;
   logic [ID_W-1:0]      id_a;
   logic [1:0]           qos_a;
   logic                 valid_a;
   logic                 ready_a;

   logic [PAYLOAD_W-1:0] payload_b;
   logic [ID_W-1:0]      id_b;
   logic [1:0]           qos_b;
   logic                 valid_b;
   logic                 ready_b;

   logic                 valid_c;
   logic                 ready_c;
   logic [PAYLOAD_W-1:0] payload_c;
   logic [ID_W:0]        id_c;
   logic [1:0]           qos_c;
   logic                 conflict_c;
   logic                 release_c;
   logic [ID_W:0]        releaseid_c;

   logic [ID_W+1:0]      outstanding;
   logic [1:0]           max_qos;
   logic                 rel_err;

   modport master (
      output payload_a, id_a, qos_a, valid_a,
      output payload_b, id_b, qos_b, valid_b,
      output ready_c, conflict_c, release_c, releaseid_c,
      input  ready_a, ready_b,
      input  valid_c, payload_c, id_c, qos_c,
      input  outstanding, max_qos, rel_err
   );

   modport slave (
      input  payload_a, id_a, qos_a, valid_a,
      input  payload_b, id_b, qos_b, valid_b,
      input  ready_c, conflict_c, release_c, releaseid_c,
      output ready_a, ready_b,
      output valid_c, payload_c, id_c, qos_c,
      output outstanding, max_qos, rel_err
   );
endinterface

// File: rtl/enigma_buf_sched.sv
// Two-port QoS scheduler into one registered output slot, with round-robin tie-break,
// starvation aging and an in-flight composite-id scoreboard that blocks reuse until release.
module enigma_buf_sched #(
   parameter int PAYLOAD_W  = 128,
   parameter int ID_W       = 5,
   parameter int AGE_MAX    = 15,
   parameter int URGENT_QOS = 3
) (
   input logic clk,
   input logic rst_n,
   enigma_buf_sched_if.slave bus
);
   localparam int CID_W = ID_W + 1;
   localparam int DEPTH = 1 << CID_W;
   localparam int CNT_W = ID_W + 2;
   localparam logic [3:0] AGE_LIM = 4'(AGE_MAX);
   localparam logic [1:0] URG_QOS = 2'(URGENT_QOS);

   logic                 valid_c_q, valid_c_d;
   logic [PAYLOAD_W-1:0] payload_c_q, payload_c_d;
   logic [CID_W-1:0]     id_c_q, id_c_d;
   logic [1:0]           qos_c_q, qos_c_d;
   logic [DEPTH-1:0]     busy_q, busy_d;
   logic [CNT_W-1:0]     outstanding_q, outstanding_d;
   logic [3:0]           age_a_q, age_a_d;
   logic [3:0]           age_b_q, age_b_d;
   logic                 rr_last_q, rr_last_d;   // 0 = A granted last, 1 = B
   logic                 rel_err_q, rel_err_d;

   logic [CID_W-1:0] cid_a, cid_b;
   logic             elig_a, elig_b;
   logic             aged_a, aged_b;
   logic             slot_free;
   logic             grant_a, grant_b;
   logic             rel_ok;
   logic [1:0]       max_qos_c;

   always_comb begin
      cid_a     = {1'b0, bus.id_a};
      cid_b     = {1'b1, bus.id_b};
      elig_a    = bus.valid_a & ~busy_q[cid_a] & (~bus.conflict_c | (bus.qos_a >= URG_QOS));
      elig_b    = bus.valid_b & ~busy_q[cid_b] & (~bus.conflict_c | (bus.qos_b >= URG_QOS));
      aged_a    = elig_a & (age_a_q == AGE_LIM);
      aged_b    = elig_b & (age_b_q == AGE_LIM);
      slot_free = ~valid_c_q | bus.ready_c;
      grant_a   = 1'b0;
      grant_b   = 1'b0;
      // Starved ports first, then QoS, then whichever port did not win last.
      if (slot_free) begin
         if (aged_a && aged_b) begin
            grant_a = rr_last_q;
            grant_b = ~rr_last_q;
         end else if (aged_a) begin
            grant_a = 1'b1;
         end else if (aged_b) begin
            grant_b = 1'b1;
         end else if (elig_a && elig_b) begin
            if (bus.qos_a > bus.qos_b) begin
               grant_a = 1'b1;
            end else if (bus.qos_b > bus.qos_a) begin
               grant_b = 1'b1;
            end else begin
               grant_a = rr_last_q;
               grant_b = ~rr_last_q;
            end
         end else begin
            grant_a = elig_a;
            grant_b = elig_b;
         end
      end

      max_qos_c = 2'd0;
      if (elig_a) max_qos_c = bus.qos_a;
      if (elig_b && (bus.qos_b > max_qos_c)) max_qos_c = bus.qos_b;
   end

   always_comb begin
      rel_ok    = bus.release_c & busy_q[bus.releaseid_c];
      rel_err_d = rel_err_q | (bus.release_c & ~rel_ok);

      // A granted id is never busy, a valid released id always is, so they never collide.
      busy_d = busy_q;
      if (rel_ok)  busy_d[bus.releaseid_c] = 1'b0;
      if (grant_a) busy_d[cid_a] = 1'b1;
      if (grant_b) busy_d[cid_b] = 1'b1;

      outstanding_d = outstanding_q + CNT_W'(grant_a | grant_b) - CNT_W'(rel_ok);

      age_a_d = age_a_q;
      if (grant_a || !bus.valid_a)
         age_a_d = 4'd0;
      else if (elig_a && slot_free && grant_b && (age_a_q != AGE_LIM))
         age_a_d = age_a_q + 4'd1;

      age_b_d = age_b_q;
      if (grant_b || !bus.valid_b)
         age_b_d = 4'd0;
      else if (elig_b && slot_free && grant_a && (age_b_q != AGE_LIM))
         age_b_d = age_b_q + 4'd1;

      rr_last_d = rr_last_q;
      if (grant_a) rr_last_d = 1'b0;
      if (grant_b) rr_last_d = 1'b1;

      valid_c_d   = valid_c_q;
      payload_c_d = payload_c_q;
      id_c_d      = id_c_q;
      qos_c_d     = qos_c_q;
      if (grant_a) begin
         valid_c_d   = 1'b1;
         payload_c_d = bus.payload_a;
         id_c_d      = cid_a;
         qos_c_d     = bus.qos_a;
      end else if (grant_b) begin
         valid_c_d   = 1'b1;
         payload_c_d = bus.payload_b;
         id_c_d      = cid_b;
         qos_c_d     = bus.qos_b;
      end else if (valid_c_q && bus.ready_c) begin
         valid_c_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_c_q     <= 1'b0;
         payload_c_q   <= '0;
         id_c_q        <= '0;
         qos_c_q       <= 2'd0;
         busy_q        <= '0;
         outstanding_q <= '0;
         age_a_q       <= 4'd0;
         age_b_q       <= 4'd0;
         rr_last_q     <= 1'b1;
         rel_err_q     <= 1'b0;
      end else begin
         valid_c_q     <= valid_c_d;
         payload_c_q   <= payload_c_d;
         id_c_q        <= id_c_d;
         qos_c_q       <= qos_c_d;
         busy_q        <= busy_d;
         outstanding_q <= outstanding_d;
         age_a_q       <= age_a_d;
         age_b_q       <= age_b_d;
         rr_last_q     <= rr_last_d;
         rel_err_q     <= rel_err_d;
      end
   end

   assign bus.ready_a     = grant_a;
   assign bus.ready_b     = grant_b;
   assign bus.valid_c     = valid_c_q;
   assign bus.payload_c   = payload_c_q;
   assign bus.id_c        = id_c_q;
   assign bus.qos_c       = qos_c_q;
   assign bus.outstanding = outstanding_q;
   assign bus.max_qos     = max_qos_c;
   assign bus.rel_err     = rel_err_q;
endmodule

// File: tb/tb_enigma_buf_sched.sv
// Bench for enigma_buf_sched: directed scenarios plus a randomized run, all checked
// against a transaction-level model that ranks eligible requests by a numeric priority key.
module tb_enigma_buf_sched;
   localparam int PW = 128;
   localparam int IW = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   enigma_buf_sched_if #(.PAYLOAD_W(PW), .ID_W(IW)) bus ();

   enigma_buf_sched #(.PAYLOAD_W(PW), .ID_W(IW), .AGE_MAX(15), .URGENT_QOS(3)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   // stimulus, index 0 = port A, 1 = port B
   bit          s_v[2];
   int          s_id[2];
   int          s_q[2];
   logic [PW-1:0] s_p[2];
   bit          s_rc, s_conf, s_rel;
   int          s_relid;

   // reference model state
   bit          m_busy[64];
   int          m_age[2];
   int          m_rr;
   bit          m_vc;
   logic [PW-1:0] m_pc;
   logic [5:0]  m_idc;
   logic [1:0]  m_qc;
   int          m_out;
   bit          m_relerr;

   int          e_grant;
   int          e_mq;
   bit          e_elig[2];
   bit          e_sf;
   logic        o_ra, o_rb;
   logic [1:0]  o_mq;

   int n_checks = 0;
   int n_pass = 0;

   function automatic logic [PW-1:0] rand_payload();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Priority key: starved ports outrank everything, then 2*qos, plus one for "not last winner".
   function automatic int key_of(int x);
      if (!s_v[x] || m_busy[x*32 + s_id[x]] || (s_conf && s_q[x] < 3)) return -1;
      return ((m_age[x] == 15) ? 16 : 2 * s_q[x]) + ((x != m_rr) ? 1 : 0);
   endfunction

   task automatic drive();
      bus.valid_a     = s_v[0];
      bus.id_a        = 5'(s_id[0]);
      bus.qos_a       = 2'(s_q[0]);
      bus.payload_a   = s_p[0];
      bus.valid_b     = s_v[1];
      bus.id_b        = 5'(s_id[1]);
      bus.qos_b       = 2'(s_q[1]);
      bus.payload_b   = s_p[1];
      bus.ready_c     = s_rc;
      bus.conflict_c  = s_conf;
      bus.release_c   = s_rel;
      bus.releaseid_c = 6'(s_relid);
   endtask

   task automatic set_idle();
      for (int x = 0; x < 2; x++) begin
         s_v[x] = 0; s_id[x] = 0; s_q[x] = 0; s_p[x] = '0;
      end
      s_rc = 0; s_conf = 0; s_rel = 0; s_relid = 0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 64; i++) m_busy[i] = 0;
      m_age[0] = 0; m_age[1] = 0; m_rr = 1;
      m_vc = 0; m_pc = '0; m_idc = '0; m_qc = '0; m_out = 0; m_relerr = 0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      set_idle();
      drive();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic model_step();
      int ka, kb;
      ka = key_of(0);
      kb = key_of(1);
      e_elig[0] = ka >= 0;
      e_elig[1] = kb >= 0;
      e_sf = !m_vc || s_rc;
      e_grant = -1;
      if (e_sf && (ka >= 0 || kb >= 0)) e_grant = (ka > kb) ? 0 : 1;
      e_mq = 0;
      for (int x = 0; x < 2; x++)
         if (e_elig[x] && s_q[x] > e_mq) e_mq = s_q[x];
   endtask

   task automatic model_update();
      for (int x = 0; x < 2; x++) begin
         if (e_grant == x || !s_v[x]) m_age[x] = 0;
         else if (e_elig[x] && e_sf && e_grant == 1 - x && m_age[x] < 15) m_age[x]++;
      end
      if (s_rel) begin
         if (m_busy[s_relid]) begin
            m_busy[s_relid] = 0;
            m_out--;
         end else begin
            m_relerr = 1;
         end
      end
      if (e_grant >= 0) begin
         m_busy[e_grant*32 + s_id[e_grant]] = 1;
         m_out++;
         m_rr  = e_grant;
         m_vc  = 1;
         m_pc  = s_p[e_grant];
         m_idc = 6'(e_grant*32 + s_id[e_grant]);
         m_qc  = 2'(s_q[e_grant]);
      end else if (m_vc && s_rc) begin
         m_vc = 0;
      end
   endtask

   // One clock: drive at negedge, sample comb outputs 1ns later, advance model at posedge.
   task automatic cycle();
      @(negedge clk);
      drive();
      #1;
      model_step();
      o_ra = bus.ready_a;
      o_rb = bus.ready_b;
      o_mq = bus.max_qos;
      @(posedge clk);
      model_update();
      if (e_grant >= 0)
         $display("txn t=%0t grant port=%s id=0x%02h qos=%0d out=%0d", $time,
                  (e_grant == 0) ? "A" : "B", m_idc, m_qc, m_out);
      #1;
   endtask

   task automatic test_reset();
      apply_reset();
      #1;
      n_checks++; if (bus.valid_c !== 1'b0) $display("FAIL reset_valid_c got %0b want 0", bus.valid_c); else n_pass++;
      n_checks++; if (bus.payload_c !== '0) $display("FAIL reset_payload_c got %h want 0", bus.payload_c); else n_pass++;
      n_checks++; if (bus.id_c !== 6'h00) $display("FAIL reset_id_c got %h want 00", bus.id_c); else n_pass++;
      n_checks++; if (bus.qos_c !== 2'd0) $display("FAIL reset_qos_c got %0d want 0", bus.qos_c); else n_pass++;
      n_checks++; if (bus.outstanding !== 7'd0) $display("FAIL reset_outstanding got %0d want 0", bus.outstanding); else n_pass++;
      n_checks++; if (bus.rel_err !== 1'b0) $display("FAIL reset_rel_err got %0b want 0", bus.rel_err); else n_pass++;
      n_checks++; if (bus.max_qos !== 2'd0) $display("FAIL reset_max_qos got %0d want 0", bus.max_qos); else n_pass++;
      n_checks++; if ({bus.ready_a, bus.ready_b} !== 2'b00) $display("FAIL reset_ready got %b want 00", {bus.ready_a, bus.ready_b}); else n_pass++;
   endtask

   task automatic test_single();
      logic [PW-1:0] p;
      apply_reset();
      p = rand_payload();
      s_v[0] = 1; s_id[0] = 3; s_q[0] = 1; s_p[0] = p; s_rc = 1;
      cycle();
      n_checks++; if (o_ra !== 1'b1) $display("FAIL single_ready_a got %0b want 1", o_ra); else n_pass++;
      n_checks++; if (bus.valid_c !== 1'b1) $display("FAIL single_valid_c got %0b want 1", bus.valid_c); else n_pass++;
      n_checks++; if (bus.id_c !== 6'h03) $display("FAIL single_id_c got %h want 03", bus.id_c); else n_pass++;
      n_checks++; if (bus.qos_c !== 2'd1) $display("FAIL single_qos_c got %0d want 1", bus.qos_c); else n_pass++;
      n_checks++; if (bus.payload_c !== p) $display("FAIL single_payload_c got %h want %h", bus.payload_c, p); else n_pass++;
      n_checks++; if (bus.outstanding !== 7'd1) $display("FAIL single_outstanding got %0d want 1", bus.outstanding); else n_pass++;
      s_v[0] = 0;
      cycle();
      n_checks++; if (bus.valid_c !== 1'b0) $display("FAIL single_drain got %0b want 0", bus.valid_c); else n_pass++;
   endtask

   task automatic test_aging();
      bit want_a;
      apply_reset();
      s_rc = 1; s_v[0] = 1; s_v[1] = 1; s_q[0] = 2; s_q[1] = 0;
      for (int k = 0; k < 17; k++) begin
         s_id[0] = k; s_id[1] = (k + 8) % 32;
         s_p[0] = rand_payload(); s_p[1] = rand_payload();
         s_rel = m_vc; s_relid = int'(m_idc);
         cycle();
         want_a = (k != 15);
         n_checks++; if (o_ra !== want_a || o_rb !== !want_a)
            $display("FAIL aging_grant beat=%0d got a=%0b b=%0b want a=%0b b=%0b", k, o_ra, o_rb, want_a, !want_a);
         else n_pass++;
      end
      n_checks++; if (bus.outstanding !== 7'(m_out)) $display("FAIL aging_outstanding got %0d want %0d", bus.outstanding, m_out); else n_pass++;
   endtask

   task automatic test_round_robin();
      bit want_a;
      apply_reset();
      s_rc = 1; s_v[0] = 1; s_v[1] = 1; s_q[0] = 1; s_q[1] = 1;
      for (int k = 0; k < 8; k++) begin
         s_id[0] = k; s_id[1] = k;
         s_p[0] = rand_payload(); s_p[1] = rand_payload();
         s_rel = m_vc; s_relid = int'(m_idc);
         cycle();
         want_a = (k % 2 == 0);
         n_checks++; if (o_ra !== want_a || o_rb !== !want_a)
            $display("FAIL rr_grant beat=%0d got a=%0b b=%0b want a=%0b b=%0b", k, o_ra, o_rb, want_a, !want_a);
         else n_pass++;
      end
   endtask

   task automatic test_blocking();
      apply_reset();
      s_rc = 1; s_v[0] = 1; s_id[0] = 5; s_q[0] = 1; s_p[0] = rand_payload();
      cycle();
      n_checks++; if (o_ra !== 1'b1) $display("FAIL block_first_a got %0b want 1", o_ra); else n_pass++;
      s_v[1] = 1; s_id[1] = 5; s_q[1] = 0; s_p[1] = rand_payload();
      cycle();
      n_checks++; if (o_ra !== 1'b0 || o_rb !== 1'b1) $display("FAIL block_busy got a=%0b b=%0b want a=0 b=1", o_ra, o_rb); else n_pass++;
      n_checks++; if (bus.id_c !== 6'h25) $display("FAIL block_id_c got %h want 25", bus.id_c); else n_pass++;
      s_v[1] = 0; s_rel = 1; s_relid = 6'h05;
      cycle();
      n_checks++; if (o_ra !== 1'b0) $display("FAIL block_release_cycle got %0b want 0", o_ra); else n_pass++;
      n_checks++; if (bus.outstanding !== 7'd1) $display("FAIL block_outstanding got %0d want 1", bus.outstanding); else n_pass++;
      s_rel = 0;
      cycle();
      n_checks++; if (o_ra !== 1'b1) $display("FAIL block_after_release got %0b want 1", o_ra); else n_pass++;
      n_checks++; if (bus.id_c !== 6'h05) $display("FAIL block_id_c2 got %h want 05", bus.id_c); else n_pass++;
   endtask

   task automatic test_conflict();
      apply_reset();
      s_rc = 1; s_conf = 1;
      s_v[0] = 1; s_id[0] = 1; s_q[0] = 2; s_p[0] = rand_payload();
      s_v[1] = 1; s_id[1] = 2; s_q[1] = 3; s_p[1] = rand_payload();
      cycle();
      n_checks++; if (o_ra !== 1'b0 || o_rb !== 1'b1) $display("FAIL conflict_grant got a=%0b b=%0b want a=0 b=1", o_ra, o_rb); else n_pass++;
      n_checks++; if (o_mq !== 2'd3) $display("FAIL conflict_max_qos got %0d want 3", o_mq); else n_pass++;
      s_id[1] = 3;
      cycle();
      n_checks++; if (o_ra !== 1'b0 || o_rb !== 1'b1) $display("FAIL conflict_grant2 got a=%0b b=%0b want a=0 b=1", o_ra, o_rb); else n_pass++;
      s_conf = 0; s_v[1] = 0;
      cycle();
      n_checks++; if (o_ra !== 1'b1) $display("FAIL conflict_drop got %0b want 1", o_ra); else n_pass++;
      n_checks++; if (bus.id_c !== 6'h01) $display("FAIL conflict_id_c got %h want 01", bus.id_c); else n_pass++;
   endtask

   task automatic test_stall();
      logic [PW-1:0] p;
      apply_reset();
      p = rand_payload();
      s_rc = 1; s_v[0] = 1; s_id[0] = 4; s_q[0] = 2; s_p[0] = p;
      cycle();
      s_rc = 0; s_id[0] = 6; s_p[0] = rand_payload();
      s_v[1] = 1; s_id[1] = 9; s_q[1] = 1; s_p[1] = rand_payload();
      for (int k = 0; k < 4; k++) begin
         s_rel = (k == 1); s_relid = 6'h10;
         cycle();
         n_checks++; if (o_ra !== 1'b0 || o_rb !== 1'b0) $display("FAIL stall_ready beat=%0d got a=%0b b=%0b want 0 0", k, o_ra, o_rb); else n_pass++;
         n_checks++; if (bus.valid_c !== 1'b1 || bus.id_c !== 6'h04 || bus.payload_c !== p)
            $display("FAIL stall_hold beat=%0d got v=%0b id=%h p=%h want v=1 id=04 p=%h", k, bus.valid_c, bus.id_c, bus.payload_c, p);
         else n_pass++;
      end
      n_checks++; if (bus.rel_err !== 1'b1) $display("FAIL stall_rel_err got %0b want 1", bus.rel_err); else n_pass++;
      n_checks++; if (bus.outstanding !== 7'd1) $display("FAIL stall_outstanding got %0d want 1", bus.outstanding); else n_pass++;
      s_rel = 0; s_rc = 1;
      cycle();
      n_checks++; if (o_ra !== 1'b1) $display("FAIL stall_resume got %0b want 1", o_ra); else n_pass++;
   endtask

   task automatic test_random();
      apply_reset();
      for (int k = 0; k < 400; k++) begin
         for (int x = 0; x < 2; x++) begin
            s_v[x]  = $urandom_range(0, 3) != 0;
            s_id[x] = $urandom_range(0, 3);
            s_q[x]  = $urandom_range(0, 3);
            s_p[x]  = rand_payload();
         end
         s_rc    = $urandom_range(0, 3) != 0;
         s_conf  = $urandom_range(0, 7) == 0;
         s_rel   = $urandom_range(0, 1) == 1;
         s_relid = ($urandom_range(0, 15) == 0) ? 31 : (32 * $urandom_range(0, 1) + $urandom_range(0, 3));
         cycle();
         n_checks++; if (o_ra !== (e_grant == 0) || o_rb !== (e_grant == 1))
            $display("FAIL rand_grant beat=%0d got a=%0b b=%0b want grant=%0d", k, o_ra, o_rb, e_grant);
         else n_pass++;
         n_checks++; if (o_mq !== 2'(e_mq)) $display("FAIL rand_max_qos beat=%0d got %0d want %0d", k, o_mq, e_mq); else n_pass++;
         n_checks++; if (bus.valid_c !== m_vc) $display("FAIL rand_valid_c beat=%0d got %0b want %0b", k, bus.valid_c, m_vc); else n_pass++;
         if (m_vc) begin
            n_checks++; if (bus.id_c !== m_idc || bus.qos_c !== m_qc || bus.payload_c !== m_pc)
               $display("FAIL rand_slot beat=%0d got id=%h qos=%0d want id=%h qos=%0d", k, bus.id_c, bus.qos_c, m_idc, m_qc);
            else n_pass++;
         end
         n_checks++; if (bus.outstanding !== 7'(m_out)) $display("FAIL rand_outstanding beat=%0d got %0d want %0d", k, bus.outstanding, m_out); else n_pass++;
         n_checks++; if (bus.rel_err !== m_relerr) $display("FAIL rand_rel_err beat=%0d got %0b want %0b", k, bus.rel_err, m_relerr); else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      s_rc = 0; s_v[0] = 1; s_id[0] = 2; s_q[0] = 1; s_p[0] = rand_payload();
      s_rel = 1; s_relid = 6'h3f;
      cycle();
      n_checks++; if (bus.valid_c !== 1'b1 || bus.rel_err !== 1'b1)
         $display("FAIL midrst_pre got v=%0b err=%0b want 1 1", bus.valid_c, bus.rel_err);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      n_checks++; if (bus.valid_c !== 1'b0 || bus.outstanding !== 7'd0 || bus.rel_err !== 1'b0)
         $display("FAIL midrst_clear got v=%0b out=%0d err=%0b want 0 0 0", bus.valid_c, bus.outstanding, bus.rel_err);
      else n_pass++;
      @(negedge clk);
      set_idle();
      drive();
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      set_idle();
      drive();
      model_reset();
      test_reset();
      test_single();
      test_aging();
      test_round_robin();
      test_blocking();
      test_conflict();
      test_stall();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
